// File: rtl/dmem_pkg.sv
// Shared encodings for the handshaked data memory: access sizes and controller states.
package dmem_pkg;

    typedef enum logic [1:0] {
        BYTE         = 2'b00,
        HALFWORD     = 2'b01,
        WORD         = 2'b10,
        MODE_ILLEGAL = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        CLEAR = 2'b00,
        IDLE  = 2'b01,
        WAIT  = 2'b10,
        RESP  = 2'b11
    } state_e;

    localparam int LANES = 4;

endpackage

// File: rtl/dmem_align.sv
// Combinational lane logic: byte enables, store replication, load extension, error detection.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  mode,
    input  logic        zero_ext,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wlanes,
    output logic [31:0] rdata,
    output logic        err
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rword[{addr_lo, 3'b000} +: 8];
    assign lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves one unassigned (no latch).
        be     = '0;
        wlanes = {LANES{wdata[7:0]}};
        rdata  = '0;
        err    = 1'b0;
        case (mode)
            BYTE: begin
                be    = 4'b0001 << addr_lo;
                rdata = zero_ext ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            end
            HALFWORD: begin
                err    = addr_lo[0];
                be     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wlanes = {2{wdata[15:0]}};
                rdata  = zero_ext ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            end
            WORD: begin
                err    = (addr_lo != 2'b00);
                be     = 4'b1111;
                wlanes = wdata;
                rdata  = rword;
            end
            default: err = 1'b1;
        endcase
        // A rejected access must neither write nor return data.
        if (err) begin
            be    = '0;
            rdata = '0;
        end
    end

endmodule

// File: rtl/dmem_controller.sv
// Handshaked word-organised data memory with wait states, byte-lane stores and a post-reset clear.
module dmem_controller
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter int WAIT_STATES    = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_mode,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy
);

    localparam int IDX_W = ADDR_WIDTH - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX  = '1;
    localparam logic [3:0]       WAIT_LOAD = 4'(WAIT_STATES - 1);

    logic [31:0] mem [DEPTH];

    state_e                state;
    logic [IDX_W-1:0]      clear_cnt;
    logic [3:0]            wait_cnt;
    logic                  lat_we;
    logic [1:0]            lat_mode;
    logic                  lat_unsigned;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [31:0]           lat_wdata;

    logic                  handshake;
    logic                  enter_resp;
    logic                  from_port;
    logic                  acc_we;
    logic [1:0]            acc_mode;
    logic                  acc_unsigned;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic [IDX_W-1:0]      acc_idx;
    logic [3:0]            al_be;
    logic [31:0]           al_wlanes;
    logic [31:0]           al_rdata;
    logic                  al_err;
    logic                  clear_en;
    logic                  store_en;

    assign handshake  = req_valid && req_ready;
    assign enter_resp = (WAIT_STATES == 0) ? handshake
                                           : (state == WAIT && wait_cnt == 4'd0);

    // With zero wait states the array is accessed on the handshake edge itself,
    // before the latch holds the request, so the port values are used directly.
    assign from_port    = (state == IDLE);
    assign acc_we       = from_port ? req_we       : lat_we;
    assign acc_mode     = from_port ? req_mode     : lat_mode;
    assign acc_unsigned = from_port ? req_unsigned : lat_unsigned;
    assign acc_addr     = from_port ? req_addr     : lat_addr;
    assign acc_wdata    = from_port ? req_wdata    : lat_wdata;
    assign acc_idx      = acc_addr[ADDR_WIDTH-1:2];

    dmem_align u_align (
        .mode     (acc_mode),
        .zero_ext (acc_unsigned),
        .addr_lo  (acc_addr[1:0]),
        .wdata    (acc_wdata),
        .rword    (mem[acc_idx]),
        .be       (al_be),
        .wlanes   (al_wlanes),
        .rdata    (al_rdata),
        .err      (al_err)
    );

    assign clear_en = (state == CLEAR);
    assign store_en = enter_resp && acc_we && !al_err;

    // NOTE: the array has no reset term; its contents are established by the clear sequence instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clear_en) begin
                mem[clear_cnt] <= '0;
            end else if (store_en) begin
                for (int i = 0; i < LANES; i++) begin
                    if (al_be[i]) mem[acc_idx][8*i +: 8] <= al_wlanes[8*i +: 8];
                end
            end
        end
    end

    // NOTE: all state and outputs update with non-blocking assignments so every read sees the pre-edge value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clear_cnt    <= '0;
            wait_cnt     <= '0;
            req_ready    <= 1'b0;
            busy         <= (CLEAR_ON_RESET != 0);
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_err      <= 1'b0;
            lat_we       <= 1'b0;
            lat_mode     <= 2'b00;
            lat_unsigned <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= al_err;
                rsp_rdata <= acc_we ? 32'd0 : al_rdata;
            end

            case (state)
                CLEAR: begin
                    clear_cnt <= clear_cnt + 1'b1;
                    if (clear_cnt == LAST_IDX) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                IDLE: begin
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                    if (handshake) begin
                        lat_we       <= req_we;
                        lat_mode     <= req_mode;
                        lat_unsigned <= req_unsigned;
                        lat_addr     <= req_addr;
                        lat_wdata    <= req_wdata;
                        req_ready    <= 1'b0;
                        busy         <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= RESP;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 1'b1;
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
